quad_dispatcher: RTL and testbench
==================================

Name: quad_dispatcher

Overview:
Frame-level initiator for shader_core. On start, scans the frame in 4-pixel quads, drives shader_core's px_x_base/px_y/valid_in, and collects the in-order R/G/B quad results from valid_out. Results go into a small result FIFO and are then written to the framebuffer over a valid/ready write port. Issue is credit-throttled so that framebuffer backpressure never drops a shader result.

Parameters:
H_RES, 320, horizontal pixels; must be a multiple of 4 and ≤ 512.
V_RES, 240, vertical lines; ≤ 256.
DEPTH, 8, result FIFO depth in quads; power of 2, ≥ 2.
FB_AW, 15, framebuffer quad-address width; must satisfy 2^FB_AW ≥ H_RES*V_RES/4.

Ports:
clk  in  1  system clock; all logic rises on posedge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse that begins a frame; ignored while busy.
busy  out  1  high from the cycle after an accepted start until the cycle after frame_done.
frame_done  out  1  one-cycle pulse when the last quad is accepted by the framebuffer.
err  out  1  sticky; set by a shader result that arrives with nothing in flight.
sh_valid  out  1  to shader_core valid_in; one-cycle pulse per quad.
sh_x  out  9  to shader_core px_x_base.
sh_y  out  8  to shader_core px_y.
sh_valid_out  in  1  from shader_core valid_out.
sh_R  in  32  from shader_core R_quad.
sh_G  in  32  from shader_core G_quad.
sh_B  in  32  from shader_core B_quad.
fb_we  out  1  framebuffer write valid.
fb_addr  out  FB_AW  quad index, y*(H_RES/4) + x/4.
fb_wdata  out  96  {R_quad, G_quad, B_quad}.
fb_ready  in  1  framebuffer accepts the write on a cycle with fb_we & fb_ready.

Behaviour:
- Reset values: busy=0, frame_done=0, err=0, sh_valid=0, sh_x=0, sh_y=0, fb_we=0, fb_addr=0, fb_wdata=0.
- Reset also clears the FIFO, the inflight counter, the scan counters and the retire counter, and forces IDLE. It is taken on any cycle, including mid-frame.
- State machine:
  - IDLE: on start go to ISSUE; x=0, y=0.
  - ISSUE: go to DRAIN after issuing the quad at (H_RES-4, V_RES-1).
  - DRAIN: go to IDLE on the write accept of quad N-1, where N = H_RES*V_RES/4. frame_done pulses on that same edge.
- Issue rule: in ISSUE, issue a quad in cycle t when inflight + fifo_count < DEPTH. Inflight and fifo_count are the registered values at t.
- An issue registers sh_valid=1, sh_x=x, sh_y=y, which are visible in cycle t+1. Back-to-back issue at 1 quad/cycle is allowed. sh_x/sh_y hold their last value when not issuing.
- Scan order: x += 4; at x = H_RES-4, wrap x to 0 and y += 1. Raster order, row-major.
- Inflight counter: +1 on issue, −1 on sh_valid_out. Both in one cycle leaves it unchanged.
- Shader latency may be any fixed value ≥ 1 cycle; results are in order. No tag is carried; fb_addr comes from the retire counter, 0..N-1.
- Result FIFO:
  - Push on sh_valid_out whenever inflight > 0; the credit rule guarantees it is never full at push.
  - Show-ahead: fb_we = !empty, and fb_wdata/fb_addr reflect the head entry.
  - Pop and retire counter +1 on fb_we & fb_ready.
  - Push and pop in the same cycle are both honoured.
- Framebuffer handshake: while fb_we=1 and fb_ready=0, fb_addr and fb_wdata stay stable.
- Minimum latency: sh_valid_out in cycle t gives fb_we=1 in cycle t+1.
- err: set on sh_valid_out with inflight=0, in any state. The result is discarded. err clears only on rst.
- start: ignored in ISSUE and DRAIN. A start on the same cycle as rst is ignored.
- busy: falls in the cycle after frame_done. A start in that same cycle is accepted.

Test Plan:
1. Reset: hold rst 2 cycles with shader idle → every output 0 and state IDLE; sh_valid stays 0 for 10 cycles without start.
2. Small frame, H_RES=8, V_RES=2, shader model latency 2, fb_ready=1: pulse start → sh (x,y) = (0,0),(4,0),(0,1),(4,1) on consecutive cycles. fb_addr 0,1,2,3 carry matching data. frame_done pulses once on the accept of addr 3; busy falls the next cycle.
3. Backpressure, DEPTH=8, default frame, fb_ready=0: exactly 8 quads issue, then sh_valid stays 0. Raise fb_ready → issue resumes, and fb_addr is contiguous with no loss or reordering.
4. fb_ready alternating 1/0: fb_addr/fb_wdata never change while fb_we & !fb_ready. The full frame retires all 19200 quads, with last fb_addr = 19199.
5. Spurious sh_valid_out in IDLE → err=1 and fb_we stays 0. A start pulsed while busy produces no restart, and scan order is unaffected.
6. rst mid-frame after 50 quads issued, shader also reset → busy=0 and err=0. A new start issues (0,0) first and fb_addr restarts at 0.

Source files
------------

// File: rtl/quad_dispatcher.sv
// quad_dispatcher: raster-scans a frame in 4-pixel quads into shader_core and streams in-order results to the framebuffer
module quad_dispatcher #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int DEPTH = 8,
    parameter int FB_AW = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic             sh_valid,
    output logic [8:0]       sh_x,
    output logic [7:0]       sh_y,
    input  logic             sh_valid_out,
    input  logic [31:0]      sh_R,
    input  logic [31:0]      sh_G,
    input  logic [31:0]      sh_B,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [95:0]      fb_wdata,
    input  logic             fb_ready
);
    localparam int N  = H_RES * V_RES / 4;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [8:0]       X_LAST  = 9'(H_RES - 4);
    localparam logic [7:0]       Y_LAST  = 8'(V_RES - 1);
    localparam logic [FB_AW-1:0] A_LAST  = FB_AW'(N - 1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;

    logic [8:0]    x;
    logic [7:0]    y;
    logic [CW-1:0] inflight, count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [95:0]   mem [DEPTH];
    logic          issue, push, pop, last_quad, last_retire, accept;

    // Credits cover both results still in the shader and results parked in the FIFO
    assign issue       = state == ISSUE && (inflight + count) < DEPTH_C;
    assign push        = sh_valid_out && inflight != '0;
    assign pop         = fb_we && fb_ready;
    assign accept      = state == IDLE && start;
    assign last_quad   = x == X_LAST && y == Y_LAST;
    assign last_retire = pop && fb_addr == A_LAST;
    assign fb_we       = count != '0;
    assign fb_wdata    = fb_we ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = issue && last_quad ? DRAIN : ISSUE;
            DRAIN:   state_nx = last_retire ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            sh_valid   <= 1'b0;
            sh_x       <= '0;
            sh_y       <= '0;
            x          <= '0;
            y          <= '0;
            inflight   <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fb_addr    <= '0;
        end else begin
            frame_done <= state == DRAIN && last_retire;
            busy       <= accept || (busy && !frame_done);
            sh_valid   <= issue;
            if (issue) begin
                sh_x <= x;
                sh_y <= y;
                x    <= x == X_LAST ? '0 : x + 9'd4;
                y    <= x == X_LAST ? y + 8'd1 : y;
            end
            if (accept) begin
                x <= '0;
                y <= '0;
            end
            inflight <= inflight + CW'(issue) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
            if (sh_valid_out && inflight == '0) err <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                fb_addr <= last_retire ? '0 : fb_addr + FB_AW'(1);
            end
        end
    end

    always_ff @(posedge clk) if (push) mem[wr_ptr] <= {sh_R, sh_G, sh_B};
endmodule

// File: tb/tb_quad_dispatcher.sv
// tb_quad_dispatcher: scoreboard bench driving a default-size and an 8x2 quad_dispatcher with latency-2 shader models
module tb_quad_dispatcher;
    typedef struct packed { logic [8:0] x; logic [7:0] y; } xy_t;
    typedef struct packed { logic [14:0] a; logic [95:0] d; } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    xy_t iq0[$], iq1[$];
    wr_t wq0[$], wq1[$];
    int nis[2];
    int ndone[2];
    logic fin[2];
    logic pfd[2];
    logic [14:0] last_a[2];

    logic start0, busy0, frame_done0, err0, sh_valid0, sh_valid_out0, fb_we0, fb_ready0, spur;
    logic [8:0] sh_x0;
    logic [7:0] sh_y0;
    logic [31:0] sh_R0, sh_G0, sh_B0;
    logic [14:0] fb_addr0;
    logic [95:0] fb_wdata0;

    logic start1, busy1, frame_done1, err1, sh_valid1, sh_valid_out1, fb_we1, fb_ready1;
    logic [8:0] sh_x1;
    logic [7:0] sh_y1;
    logic [31:0] sh_R1, sh_G1, sh_B1;
    logic [1:0] fb_addr1;
    logic [95:0] fb_wdata1;

    quad_dispatcher dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .frame_done(frame_done0), .err(err0),
        .sh_valid(sh_valid0), .sh_x(sh_x0), .sh_y(sh_y0), .sh_valid_out(sh_valid_out0),
        .sh_R(sh_R0), .sh_G(sh_G0), .sh_B(sh_B0), .fb_we(fb_we0), .fb_addr(fb_addr0),
        .fb_wdata(fb_wdata0), .fb_ready(fb_ready0)
    );

    quad_dispatcher #(.H_RES(8), .V_RES(2), .DEPTH(8), .FB_AW(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .frame_done(frame_done1), .err(err1),
        .sh_valid(sh_valid1), .sh_x(sh_x1), .sh_y(sh_y1), .sh_valid_out(sh_valid_out1),
        .sh_R(sh_R1), .sh_G(sh_G1), .sh_B(sh_B1), .fb_we(fb_we1), .fb_addr(fb_addr1),
        .fb_wdata(fb_wdata1), .fb_ready(fb_ready1)
    );

    function automatic logic [95:0] shade(input logic [8:0] x, input logic [7:0] y);
        logic [31:0] r;
        r = {x, y, 15'h2B3C};
        return {r, ~r, r ^ 32'h0F0F_5A5A};
    endfunction

    // Shader models: fixed latency 2, in order
    logic [1:0] pv0, pv1;
    xy_t pa0, pb0, pa1, pb1;
    always @(posedge clk) begin
        pv0 <= rst ? 2'b0 : {pv0[0], sh_valid0};
        pv1 <= rst ? 2'b0 : {pv1[0], sh_valid1};
        pa0 <= xy_t'({sh_x0, sh_y0});
        pb0 <= pa0;
        pa1 <= xy_t'({sh_x1, sh_y1});
        pb1 <= pa1;
    end
    assign sh_valid_out0 = pv0[1] | spur;
    assign sh_valid_out1 = pv1[1];
    assign {sh_R0, sh_G0, sh_B0} = shade(pb0.x, pb0.y);
    assign {sh_R1, sh_G1, sh_B1} = shade(pb1.x, pb1.y);

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic mon(input int i, input logic sv, input logic [8:0] x, input logic [7:0] y,
                       input logic we, input logic rdy, input logic [14:0] a, input logic [95:0] d,
                       input logic fd, input logic bz, input int n);
        xy_t e;
        wr_t w;
        logic have;
        if (sv) begin
            have = i == 0 ? iq0.size() != 0 : iq1.size() != 0;
            chk("issue_expected", have, 1);
            if (have) begin
                e = i == 0 ? iq0.pop_front() : iq1.pop_front();
                chk("sh_xy", {x, y}, e);
            end
            nis[i]++;
        end
        if (we) begin
            have = i == 0 ? wq0.size() != 0 : wq1.size() != 0;
            chk("write_expected", have, 1);
            if (have) begin
                w = i == 0 ? wq0[0] : wq1[0];
                chk("fb_addr", a, w.a);
                chk("fb_wdata", d, w.d);
                if (rdy) begin
                    if (i == 0) void'(wq0.pop_front());
                    else void'(wq1.pop_front());
                    last_a[i] = a;
                end
            end
        end
        if (pfd[i]) chk("busy_fall", bz, 0);
        chk("frame_done", fd, fin[i]);
        if (fd) ndone[i]++;
        fin[i] = we && rdy && a == 15'(n - 1);
        pfd[i] = fd;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, sh_valid0, sh_x0, sh_y0, fb_we0, fb_ready0, fb_addr0, fb_wdata0, frame_done0, busy0, 19200);
            mon(1, sh_valid1, sh_x1, sh_y1, fb_we1, fb_ready1, 15'(fb_addr1), fb_wdata1, frame_done1, busy1, 4);
        end else begin
            for (int i = 0; i < 2; i++) begin
                fin[i] = 1'b0;
                pfd[i] = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int i, input int h, input int v);
        for (int yy = 0; yy < v; yy++)
            for (int xx = 0; xx < h; xx += 4) begin
                if (i == 0) begin
                    iq0.push_back(xy_t'({9'(xx), 8'(yy)}));
                    wq0.push_back(wr_t'({15'(yy * (h / 4) + xx / 4), shade(9'(xx), 8'(yy))}));
                end else begin
                    iq1.push_back(xy_t'({9'(xx), 8'(yy)}));
                    wq1.push_back(wr_t'({15'(yy * (h / 4) + xx / 4), shade(9'(xx), 8'(yy))}));
                end
            end
        nis[i] = 0;
        if (i == 0) start0 = 1'b1;
        else start1 = 1'b1;
        tick;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, input logic alt);
        int d0;
        int c;
        d0 = ndone[i];
        c = 0;
        while (ndone[i] == d0 && c < budget) begin
            if (alt) fb_ready0 = ~fb_ready0;
            tick;
            c++;
        end
        chk("done_in_budget", ndone[i] != d0, 1);
        repeat (3) tick;
    endtask

    initial begin
        int c;
        start0 = 1'b0;
        start1 = 1'b0;
        spur = 1'b0;
        fb_ready0 = 1'b1;
        fb_ready1 = 1'b1;
        start0 = 1'b1;
        repeat (2) tick;
        start0 = 1'b0;
        chk("rst_ctrl", {busy0, frame_done0, err0, sh_valid0, fb_we0, busy1, frame_done1, err1, sh_valid1, fb_we1}, 0);
        chk("rst_pos", {sh_x0, sh_y0, fb_addr0, sh_x1, sh_y1, fb_addr1}, 0);
        chk("rst_wdata", fb_wdata0, 0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("idle_sh_valid", {sh_valid0, sh_valid1, busy0}, 0);
        end

        frame(1, 8, 2);
        c = 0;
        while (!sh_valid1 && c < 5) begin
            tick;
            c++;
        end
        for (int k = 0; k < 4; k++) begin
            chk("b2b_issue", sh_valid1, 1);
            tick;
        end
        chk("small_issue_end", sh_valid1, 0);
        wait_done(1, 50, 1'b0);
        chk("small_done_once", ndone[1], 1);
        chk("small_last_addr", last_a[1], 3);

        fb_ready0 = 1'b0;
        frame(0, 320, 240);
        repeat (40) tick;
        chk("stall_issue_cnt", nis[0], 8);
        chk("stall_fb_we", fb_we0, 1);
        repeat (20) tick;
        chk("stall_hold", nis[0], 8);
        fb_ready0 = 1'b1;
        wait_done(0, 25000, 1'b0);
        chk("bp_issued", nis[0], 19200);
        chk("bp_last_addr", last_a[0], 19199);

        frame(0, 320, 240);
        wait_done(0, 50000, 1'b1);
        fb_ready0 = 1'b1;
        chk("alt_done_cnt", ndone[0], 2);
        chk("alt_last_addr", last_a[0], 19199);
        chk("alt_left", wq0.size(), 0);

        spur = 1'b1;
        tick;
        spur = 1'b0;
        repeat (3) tick;
        chk("err_set", err0, 1);
        chk("spur_no_we", fb_we0, 0);

        frame(0, 320, 240);
        repeat (5) tick;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (10) tick;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        c = 0;
        while (nis[0] < 50 && c < 200) begin
            tick;
            c++;
        end
        chk("reach_50", nis[0] >= 50, 1);
        rst = 1'b1;
        iq0.delete();
        wq0.delete();
        iq1.delete();
        wq1.delete();
        repeat (2) tick;
        rst = 1'b0;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_err", err0, 0);
        chk("mid_rst_addr", fb_addr0, 0);
        frame(0, 320, 240);
        repeat (60) tick;
        chk("restart_progress", nis[0] > 20, 1);
        chk("restart_retired", last_a[0] < 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
